// File: rtl/qpimem_arbiter.sv
// qpimem_arbiter
//   Shares one QPI PSRAM engine (qpimem_iface) between two burst requesters.
//   Requests are granted round-robin, split at PSRAM page boundaries into
//   engine transactions, and streamed through the engine's
//   do_read/do_write/next_byte handshake. The arbiter waits for the engine to
//   report idle between transactions.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid[1:0]    per-port request pending, held until req_ready
//   req_write[1:0]    per-port 1=write burst, 0=read burst
//   req_addr[47:0]    per-port 24-bit byte address (port p = bits 24p+23:24p)
//   req_len           per-port burst length in 32-bit words (LENW bits each)
//   req_ready[1:0]    one-cycle accept pulse, request fields latched
//   wdata[63:0]       per-port current write word
//   wdata_next[1:0]   one-cycle pulse, current write word consumed
//   rdata[31:0]       read word shared by both ports
//   rdata_valid[1:0]  one-cycle pulse, rdata valid for that port
//   done[1:0]         one-cycle pulse, burst complete and engine idle
//   mem_*             engine side: do_read, do_write, addr, wdata, next, rdata, idle
module qpimem_arbiter #(
  parameter int LENW          = 8,
  parameter int PAGE_BYTES    = 1024,
  parameter int MIN_RD_ASSERT = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [47:0]         req_addr,
  input  logic [2*LENW-1:0]   req_len,
  output logic [1:0]          req_ready,
  input  logic [63:0]         wdata,
  output logic [1:0]          wdata_next,
  output logic [31:0]         rdata,
  output logic [1:0]          rdata_valid,
  output logic [1:0]          done,
  output logic                mem_do_read,
  output logic                mem_do_write,
  output logic [23:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_next,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_idle
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] XFER      = 2'd1;
  localparam logic [1:0] WAIT_IDLE = 2'd2;

  localparam int PAGE_WORDS = PAGE_BYTES / 4;
  localparam int CW         = $clog2(MIN_RD_ASSERT + 1);

  logic [1:0]      state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            last_q, last_d;
  logic            write_q, write_d;
  logic [23:0]     addr_q, addr_d;
  logic [LENW-1:0] seg_q, seg_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic [LENW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            rdStop_q, rdStop_d;
  logic [1:0]      done_q, done_d;

  // Words that fit in this transaction: the smaller of what is left and the
  // distance to the end of the current PSRAM page.
  function automatic logic [LENW-1:0] segLen(input logic [23:0] a, input logic [LENW-1:0] remain);
    logic [31:0] offs;
    logic [31:0] toPage;
    offs   = (32'(a) >> 2) & 32'(PAGE_WORDS - 1);
    toPage = 32'(PAGE_WORDS) - offs;
    if (32'(remain) < toPage) segLen = remain;
    else                      segLen = toPage[LENW-1:0];
  endfunction

  logic            grantEn;
  logic            grantPort;
  logic [23:0]     reqAddr;
  logic [LENW-1:0] reqLen;
  logic [LENW-1:0] firstSeg;
  logic [1:0]      gntMask;
  logic            inXfer;
  logic            lastPulse;
  logic [LENW:0]   pulsesSoFar;
  logic            pulsesOk;
  logic            elapsedOk;
  logic [23:0]     nextAddr;
  logic [LENW-1:0] nextSeg;

  // Grant is held off during a done pulse so a waiting port is only accepted
  // after the previous owner has been told its burst is complete.
  always_comb begin
    grantEn   = (state_q == IDLE) && mem_idle && !rst && (done_q == 2'b00) && (req_valid != 2'b00);
    grantPort = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    reqAddr   = (grantPort ? req_addr[47:24] : req_addr[23:0]) & 24'hFFFFFC;
    reqLen    = grantPort ? req_len[2*LENW-1:LENW] : req_len[LENW-1:0];
    firstSeg  = segLen(reqAddr, reqLen);
    req_ready = grantEn ? (grantPort ? 2'b10 : 2'b01) : 2'b00;
  end

  // Transfer-phase bookkeeping. The read strobe must cover the command and
  // address phases, so it only drops once both the word count and the
  // minimum assertion time are satisfied.
  always_comb begin
    gntMask     = gnt_q ? 2'b10 : 2'b01;
    inXfer      = (state_q == XFER);
    lastPulse   = inXfer && mem_next && (cnt_q == seg_q - 1'b1);
    pulsesSoFar = {1'b0, cnt_q} + {{LENW{1'b0}}, mem_next};
    pulsesOk    = pulsesSoFar >= {1'b0, seg_q - 1'b1};
    elapsedOk   = cyc_q >= CW'(MIN_RD_ASSERT - 1);
    nextAddr    = addr_q + {seg_q, 2'b00};
    nextSeg     = segLen(nextAddr, rem_q);
  end

  always_comb begin
    mem_do_read  = inXfer && !write_q && !rdStop_q;
    mem_do_write = inXfer && write_q && !lastPulse;
    mem_addr     = addr_q;
    mem_wdata    = (inXfer && write_q) ? (gnt_q ? wdata[63:32] : wdata[31:0]) : 32'd0;
    rdata        = (inXfer && !write_q) ? mem_rdata : 32'd0;
    rdata_valid  = (inXfer && !write_q && mem_next) ? gntMask : 2'b00;
    wdata_next   = (inXfer && write_q && mem_next) ? gntMask : 2'b00;
    done         = done_q;
  end

  // Sequencer: accept a burst, stream each page-bounded segment, then wait for
  // the engine to go idle before starting the next segment or finishing.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    write_d  = write_q;
    addr_d   = addr_q;
    seg_d    = seg_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    cyc_d    = cyc_q;
    rdStop_d = rdStop_q;
    done_d   = 2'b00;
    case (state_q)
      IDLE: begin
        if (grantEn) begin
          gnt_d   = grantPort;
          last_d  = grantPort;
          write_d = req_write[grantPort];
          addr_d  = reqAddr;
          if (reqLen == '0) begin
            done_d = grantPort ? 2'b10 : 2'b01;
          end else begin
            seg_d    = firstSeg;
            rem_d    = reqLen - firstSeg;
            cnt_d    = '0;
            cyc_d    = '0;
            rdStop_d = 1'b0;
            state_d  = XFER;
          end
        end
      end
      XFER: begin
        if (mem_next) cnt_d = cnt_q + 1'b1;
        if (cyc_q != CW'(MIN_RD_ASSERT)) cyc_d = cyc_q + 1'b1;
        if (!write_q && pulsesOk && elapsedOk) rdStop_d = 1'b1;
        if (lastPulse) state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (mem_idle) begin
          if (rem_q != '0) begin
            addr_d   = nextAddr;
            seg_d    = nextSeg;
            rem_d    = rem_q - nextSeg;
            cnt_d    = '0;
            cyc_d    = '0;
            rdStop_d = 1'b0;
            state_d  = XFER;
          end else begin
            done_d  = gntMask;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Port 0 wins the first tie after reset because the pointer claims port 1
  // was granted last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      write_q  <= 1'b0;
      addr_q   <= '0;
      seg_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      cyc_q    <= '0;
      rdStop_q <= 1'b0;
      done_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      seg_q    <= seg_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      cyc_q    <= cyc_d;
      rdStop_q <= rdStop_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_qpimem_arbiter.sv
// tb_qpimem_arbiter
//   Directed bench for qpimem_arbiter. A small behavioural engine model answers
//   the do_read/do_write handshake (read data appears after the command phase,
//   write words are taken every other cycle) and logs each transaction.
module tb_qpimem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [47:0] req_addr;
  logic [15:0] req_len;
  logic [1:0]  req_ready;
  logic [63:0] wdata;
  logic [1:0]  wdata_next;
  logic [31:0] rdata;
  logic [1:0]  rdata_valid;
  logic [1:0]  done;
  logic        mem_do_read;
  logic        mem_do_write;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_next  = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_idle  = 1'b1;

  qpimem_arbiter #(.LENW(8), .PAGE_BYTES(1024), .MIN_RD_ASSERT(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .wdata(wdata), .wdata_next(wdata_next),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done),
    .mem_do_read(mem_do_read), .mem_do_write(mem_do_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_next(mem_next), .mem_rdata(mem_rdata), .mem_idle(mem_idle)
  );

  always #5 clk = ~clk;

  // Engine model: samples the arbiter at the clock edge, answers 1 time unit later.
  int          eSt = 0;
  int          eLat = 0;
  int          eTail = 0;
  int          ePulses = 0;
  logic        eWr = 1'b0;
  logic        sRst, sRd, sWr;
  logic [31:0] sW;
  logic [23:0] sA;
  logic [23:0] txAddr[$];
  logic        txWrite[$];
  int          txPulses[$];
  logic [31:0] wLog[$];

  always @(posedge clk) begin
    sRst = rst; sRd = mem_do_read; sWr = mem_do_write; sW = mem_wdata; sA = mem_addr;
    #1;
    if (sRst) begin
      if (eSt != 0) txPulses.push_back(ePulses);
      eSt = 0; mem_idle = 1'b1; mem_next = 1'b0; mem_rdata = 32'd0;
    end else begin
      case (eSt)
        0: if (sRd || sWr) begin
          eSt = 1; eWr = sWr; eLat = sWr ? 3 : 9; ePulses = 0; mem_idle = 1'b0;
          txAddr.push_back(sA); txWrite.push_back(sWr);
        end
        1: begin
          eLat--;
          if (eLat == 0) begin mem_next = 1'b1; mem_rdata = 32'hA0; eSt = 2; end
        end
        2: begin
          ePulses++;
          if (eWr) wLog.push_back(sW);
          if (!(sRd || sWr)) begin
            mem_next = 1'b0; mem_rdata = 32'd0; eSt = 3; eTail = 2; txPulses.push_back(ePulses);
          end else if (eWr) begin
            mem_next = 1'b0; eSt = 4;
          end else begin
            mem_rdata = 32'hA0 + 32'(ePulses);
          end
        end
        4: begin mem_next = 1'b1; eSt = 2; end
        3: begin
          eTail--;
          if (eTail == 0) begin mem_idle = 1'b1; eSt = 0; end
        end
        default: eSt = 0;
      endcase
    end
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          readyCnt[2], rvCnt[2], wnCnt[2], doneCnt[2], lastReadyCyc[2], lastDoneCyc[2];
  int          rdHigh, wrHigh, wLow, excl;
  int          wIdx[2];
  logic        doneIdle;
  logic [31:0] rdLog0[$], rdLog1[$];
  logic [1:0]  stepRr, stepDone;
  logic        stepDoRd;
  logic [23:0] stepAddr;
  logic [9:0]  stepCtrl;
  logic [31:0] stepWdata, stepRdata;
  int          txBase, wBase;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveWdata();
    wdata = {32'hB000_0000 + 32'(wIdx[1]), 32'hC000_0000 + 32'(wIdx[0])};
  endtask

  task automatic clearStats();
    for (int p = 0; p < 2; p++) begin
      readyCnt[p] = 0; rvCnt[p] = 0; wnCnt[p] = 0; doneCnt[p] = 0;
      lastReadyCyc[p] = 0; lastDoneCyc[p] = 0;
    end
    rdHigh = 0; wrHigh = 0; wLow = 0; doneIdle = 1'b0;
    rdLog0.delete(); rdLog1.delete();
    txBase = txAddr.size(); wBase = wLog.size();
  endtask

  // One clock: observe outputs on the falling edge, then play the requester
  // (drop accepted requests, advance write words) just after the rising edge.
  task automatic applyStimulus();
    logic [1:0] wn;
    @(negedge clk);
    cyc++;
    stepRr = req_ready; stepDone = done; wn = wdata_next;
    stepDoRd = mem_do_read; stepAddr = mem_addr;
    stepCtrl = {req_ready, wdata_next, rdata_valid, done, mem_do_read, mem_do_write};
    stepWdata = mem_wdata; stepRdata = rdata;
    for (int p = 0; p < 2; p++) begin
      if (req_ready[p]) begin readyCnt[p]++; lastReadyCyc[p] = cyc; end
      if (wdata_next[p]) wnCnt[p]++;
      if (done[p]) begin doneCnt[p]++; lastDoneCyc[p] = cyc; doneIdle = mem_idle; end
    end
    if (rdata_valid[0]) begin rvCnt[0]++; rdLog0.push_back(rdata); end
    if (rdata_valid[1]) begin rvCnt[1]++; rdLog1.push_back(rdata); end
    if (mem_do_read) rdHigh++;
    if (mem_do_write) wrHigh++;
    if ((wn != 2'b00) && !mem_do_write) wLow++;
    if (mem_do_read && mem_do_write) excl++;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~stepRr;
    for (int p = 0; p < 2; p++) if (wn[p]) wIdx[p]++;
    driveWdata();
  endtask

  task automatic waitReady(input int p, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      applyStimulus();
      if (stepRr[p]) ok = 1'b1;
    end
    if (!ok) checkOutput(tag, 64'd0, 64'd1);
  endtask

  task automatic waitDone(input int p, input string tag);
    int start;
    logic ok;
    start = doneCnt[p];
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      applyStimulus();
      if (doneCnt[p] > start) ok = 1'b1;
    end
    if (!ok) checkOutput(tag, 64'd0, 64'd1);
  endtask

  function automatic logic [23:0] txA(input int i);
    return (i < txAddr.size()) ? txAddr[i] : 24'hFFFFFF;
  endfunction

  function automatic int txP(input int i);
    return (i < txPulses.size()) ? txPulses[i] : -1;
  endfunction

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_len = '0;
    excl = 0; wIdx[0] = 0; wIdx[1] = 0; driveWdata();
    clearStats();
    applyStimulus();
    applyStimulus();
    checkOutput("resetCtrl", 64'(stepCtrl), 64'd0);
    checkOutput("resetAddr", 64'(stepAddr), 64'd0);
    rst = 1'b0;

    // Simultaneous reads after reset: port 0 first, port 1 after done[0]
    $display("[TB] tie after reset");
    clearStats();
    req_write = 2'b00; req_addr = {24'h000300, 24'h000200}; req_len = {8'd2, 8'd2};
    req_valid = 2'b11;
    waitReady(0, "tieReady0");
    checkOutput("tieFirstGrant", 64'(readyCnt[1]), 64'd0);
    waitDone(1, "tieDone1");
    checkOutput("tieP1AfterDone0", 64'(lastReadyCyc[1] > lastDoneCyc[0]), 64'd1);
    checkOutput("tieTxCount", 64'(txAddr.size() - txBase), 64'd2);
    checkOutput("tieTxAddr0", 64'(txA(txBase)), 64'h200);
    checkOutput("tieTxAddr1", 64'(txA(txBase + 1)), 64'h300);
    checkOutput("tieRv", 64'({rvCnt[1][7:0], rvCnt[0][7:0]}), 64'h0202);

    // Repeat the tie: pointer now favours port 0 again
    $display("[TB] tie repeat");
    clearStats();
    req_valid = 2'b11;
    waitReady(0, "tie2Ready0");
    checkOutput("tie2FirstGrant", 64'(readyCnt[1]), 64'd0);
    waitDone(1, "tie2Done1");
    checkOutput("tie2Done", 64'({doneCnt[1][7:0], doneCnt[0][7:0]}), 64'h0101);

    // Port 0 read of four words
    $display("[TB] port0 read len 4");
    clearStats();
    req_write = 2'b00; req_addr = {24'h0, 24'h000100}; req_len = {8'd0, 8'd4};
    req_valid = 2'b01;
    waitReady(0, "rd4Ready");
    applyStimulus();
    checkOutput("rd4FirstDoRead", 64'(stepDoRd), 64'd1);
    checkOutput("rd4MemAddr", 64'(stepAddr), 64'h000100);
    waitDone(0, "rd4Done");
    checkOutput("rd4RvCnt", 64'(rvCnt[0]), 64'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("rd4Data", 64'((i < rdLog0.size()) ? rdLog0[i] : 32'hDEAD), 64'(32'hA0 + 32'(i)));
    checkOutput("rd4DoneCnt", 64'(doneCnt[0]), 64'd1);
    checkOutput("rd4Port1Quiet", 64'(rvCnt[1] + wnCnt[1] + doneCnt[1] + readyCnt[1]), 64'd0);
    checkOutput("rd4TxCount", 64'(txAddr.size() - txBase), 64'd1);
    checkOutput("rd4TxPulses", 64'(txP(txBase)), 64'd4);

    // Port 1 write of three words crossing a page boundary
    $display("[TB] port1 write across page");
    clearStats();
    wIdx[1] = 0; driveWdata();
    req_write = 2'b10; req_addr = {24'h0003F8, 24'h0}; req_len = {8'd3, 8'd0};
    req_valid = 2'b10;
    waitReady(1, "wrReady");
    waitDone(1, "wrDone");
    checkOutput("wrTxCount", 64'(txAddr.size() - txBase), 64'd2);
    checkOutput("wrTxAddr0", 64'(txA(txBase)), 64'h0003F8);
    checkOutput("wrTxPulses0", 64'(txP(txBase)), 64'd2);
    checkOutput("wrTxAddr1", 64'(txA(txBase + 1)), 64'h000400);
    checkOutput("wrTxPulses1", 64'(txP(txBase + 1)), 64'd1);
    checkOutput("wrNextCnt", 64'(wnCnt[1]), 64'd3);
    checkOutput("wrLowInLast", 64'(wLow), 64'd2);
    for (int i = 0; i < 3; i++)
      checkOutput("wrData", 64'((wBase + i < wLog.size()) ? wLog[wBase + i] : 32'hDEAD), 64'(32'hB000_0000 + 32'(i)));
    checkOutput("wrDoneCnt", 64'({doneCnt[1][7:0], doneCnt[0][7:0]}), 64'h0100);
    checkOutput("wrPort0Quiet", 64'(wnCnt[0] + rvCnt[0] + readyCnt[0]), 64'd0);

    // Single-word read: strobe held for the minimum time
    $display("[TB] port0 read len 1");
    clearStats();
    req_write = 2'b00; req_addr = {24'h0, 24'h000500}; req_len = {8'd0, 8'd1};
    req_valid = 2'b01;
    waitReady(0, "rd1Ready");
    waitDone(0, "rd1Done");
    checkOutput("rd1HighCycles", 64'(rdHigh), 64'd10);
    checkOutput("rd1RvCnt", 64'(rvCnt[0]), 64'd1);
    checkOutput("rd1Data", 64'((rdLog0.size() > 0) ? rdLog0[0] : 32'hDEAD), 64'hA0);
    checkOutput("rd1DoneIdle", 64'(doneIdle), 64'd1);

    // Zero-length request
    $display("[TB] zero length");
    clearStats();
    req_addr = {24'h000010, 24'h0}; req_len = {8'd0, 8'd0};
    req_valid = 2'b10;
    waitReady(1, "len0Ready");
    applyStimulus();
    checkOutput("len0DoneNext", 64'(stepDone), 64'b10);
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("len0NoEngine", 64'(rdHigh + wrHigh), 64'd0);
    checkOutput("len0NoTx", 64'(txAddr.size() - txBase), 64'd0);
    checkOutput("len0DoneCnt", 64'(doneCnt[1]), 64'd1);

    // Reset in the middle of a write burst, then a fresh re-request
    $display("[TB] reset mid-write");
    clearStats();
    wIdx[0] = 0; driveWdata();
    req_write = 2'b01; req_addr = {24'h0, 24'h000010}; req_len = {8'd0, 8'd4};
    req_valid = 2'b01;
    waitReady(0, "rstReady");
    req_valid = 2'b01;
    for (int i = 0; i < 100 && wnCnt[0] < 2; i++) applyStimulus();
    checkOutput("rstMidBurst", 64'(wnCnt[0]), 64'd2);
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("rstCtrl", 64'(stepCtrl), 64'd0);
    checkOutput("rstAddr", 64'(stepAddr), 64'd0);
    checkOutput("rstWdata", 64'(stepWdata), 64'd0);
    checkOutput("rstRdata", 64'(stepRdata), 64'd0);
    checkOutput("rstNoDone", 64'(doneCnt[0]), 64'd0);
    rst = 1'b0;
    wIdx[0] = 0; driveWdata();
    clearStats();
    waitReady(0, "rstRegrant");
    waitDone(0, "rstDone");
    checkOutput("rstTxAddr", 64'(txA(txBase)), 64'h000010);
    checkOutput("rstTxPulses", 64'(txP(txBase)), 64'd4);
    checkOutput("rstNextCnt", 64'(wnCnt[0]), 64'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("rstData", 64'((wBase + i < wLog.size()) ? wLog[wBase + i] : 32'hDEAD), 64'(32'hC000_0000 + 32'(i)));
    checkOutput("rstDoneCnt", 64'(doneCnt[0]), 64'd1);

    checkOutput("mutexDoStrobes", 64'(excl), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
